// File: rtl/alarme_atuador.sv
// alarme_atuador: response end of the 2-of-3 button alarm.
// Synchronises the majority trigger, debounces the arm/acknowledge buttons and runs the
// DESARMADO -> ARMADO -> ATRASO -> ALARME controller that drives the LED and siren.
// Optional feature macro: ALARME_AUTO_REARM_EN (siren timeout with automatic re-arm).
module alarme_atuador #(
  parameter int unsigned ENTRY_DELAY_CYC   = 50000000,
  parameter int unsigned BLINK_HALF_CYC    = 12500000,
  parameter int unsigned DEB_CYC           = 500000,
  parameter int unsigned SIREN_TIMEOUT_CYC = 500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       disparo,
  input  logic       armar,
  input  logic       reconhecer,
  output logic       led,
  output logic       sirene,
  output logic [1:0] estado,
  output logic [7:0] evento_cnt
);

  // Zero-length delays would make the down-counters underflow on load.
  if (ENTRY_DELAY_CYC < 1 || BLINK_HALF_CYC < 1 || DEB_CYC < 1 || SIREN_TIMEOUT_CYC < 1)
  begin : g_bad_param
    $error("alarme_atuador: every cycle-count parameter must be at least 1");
  end

  localparam int unsigned DebW   = $clog2(DEB_CYC + 1);
  localparam int unsigned DlyW   = $clog2(ENTRY_DELAY_CYC + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_HALF_CYC + 1);

  localparam logic [DebW-1:0]   DebLast   = DebW'(DEB_CYC - 1);
  localparam logic [DlyW-1:0]   DlyLoad   = DlyW'(ENTRY_DELAY_CYC - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF_CYC - 1);

  typedef enum logic [1:0] {
    StDesarmado = 2'd0,
    StArmado    = 2'd1,
    StAtraso    = 2'd2,
    StAlarme    = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [1:0]      disp_sync_q, arm_sync_q, ack_sync_q;
  logic            disp_s;
  logic [1:0]      btn_s;        // [0] = armar, [1] = reconhecer (synchronised)
  logic [DebW-1:0] deb_cnt_q [2];
  logic [1:0]      deb_q, deb_prev_q, pulse_q;
  logic            arm_p, ack_p;

  // Two-flop synchronisers for all three asynchronous inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_sync_q <= '0;
      arm_sync_q  <= '0;
      ack_sync_q  <= '0;
    end else begin
      disp_sync_q <= {disp_sync_q[0], disparo};
      arm_sync_q  <= {arm_sync_q[0], armar};
      ack_sync_q  <= {ack_sync_q[0], reconhecer};
    end
  end

  assign disp_s = disp_sync_q[1];
  assign btn_s  = {ack_sync_q[1], arm_sync_q[1]};

  // Debounce: accept a new level after DEB_CYC consecutive cycles that disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= '0;
      end
      deb_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_s[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DebLast) begin
          deb_cnt_q[i] <= '0;
          deb_q[i]     <= btn_s[i];
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DebW'(1);
        end
      end
    end
  end

  // Registered one-cycle pulse on each debounced rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_prev_q <= '0;
      pulse_q    <= '0;
    end else begin
      deb_prev_q <= deb_q;
      pulse_q    <= deb_q & ~deb_prev_q;
    end
  end

  assign arm_p = pulse_q[0];
  assign ack_p = pulse_q[1];

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  state_e            st_q, st_d;
  logic [DlyW-1:0]   dly_q;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              tog_q, tog_d;
  logic              blink_entry;
  logic              led_d;
  logic              siren_done;

`ifdef ALARME_AUTO_REARM_EN
  localparam int unsigned SirenW = $clog2(SIREN_TIMEOUT_CYC + 1);
  localparam logic [SirenW-1:0] SirenLoad = SirenW'(SIREN_TIMEOUT_CYC - 1);

  logic [SirenW-1:0] siren_q;

  // Siren timer: loads on entry to ALARME, reloads on every timeout that does not re-arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      siren_q <= '0;
    end else if (st_q != StAlarme) begin
      siren_q <= SirenLoad;
    end else if (siren_q == '0) begin
      siren_q <= SirenLoad;
    end else begin
      siren_q <= siren_q - SirenW'(1);
    end
  end

  assign siren_done = (siren_q == '0) && !disp_s;
`else
  assign siren_done = 1'b0;
`endif

  // Next-state decode; acknowledge overrides every other transition.
  always_comb begin
    st_d = st_q;
    case (st_q)
      StDesarmado: if (arm_p) st_d = StArmado;
      StArmado:    if (disp_s) st_d = StAtraso;
      StAtraso:    if (dly_q == '0) st_d = StAlarme;
      StAlarme:    if (siren_done) st_d = StArmado;
      default:     st_d = StDesarmado;
    endcase
    if (ack_p) begin
      st_d = StDesarmado;
    end
  end

  assign blink_entry = (st_d != st_q) && ((st_d == StAtraso) || (st_d == StAlarme));

  // Blink phase: restarts on entry so the first half-period is always LED on.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    tog_d       = tog_q;
    if (blink_entry) begin
      blink_cnt_d = '0;
      tog_d       = 1'b0;
    end else if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      tog_d       = ~tog_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BlinkW'(1);
    end
  end

  // LED value for the state being entered, so it lines up with estado.
  always_comb begin
    led_d = 1'b0;
    case (st_d)
      StArmado:           led_d = 1'b1;
      StAtraso, StAlarme: led_d = ~tog_d;
      default:            led_d = 1'b0;
    endcase
  end

  // State, delay counter, event counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= StDesarmado;
      dly_q       <= '0;
      blink_cnt_q <= '0;
      tog_q       <= 1'b0;
      led         <= 1'b0;
      sirene      <= 1'b0;
      estado      <= 2'd0;
      evento_cnt  <= 8'd0;
    end else begin
      st_q        <= st_d;
      blink_cnt_q <= blink_cnt_d;
      tog_q       <= tog_d;
      led         <= led_d;
      sirene      <= (st_d == StAlarme);
      estado      <= st_d;

      if (st_q == StArmado && st_d == StAtraso) begin
        dly_q <= DlyLoad;
      end else if (st_q == StAtraso && dly_q != '0) begin
        dly_q <= dly_q - DlyW'(1);
      end

      // Only a genuine expiry counts; an acknowledged expiry never reaches ALARME.
      if (st_q == StAtraso && st_d == StAlarme && evento_cnt != 8'hFF) begin
        evento_cnt <= evento_cnt + 8'd1;
      end
    end
  end

endmodule
